mem_bus_responder: RTL and testbench

Byte-wide memory and I/O responder on the far side of the core's external memory bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din`/`io_buffer_full` out). It implements the simulation/FPGA RAM with one-cycle read latency. It decodes the I/O window at 0x30000, where a transmit FIFO drains to a byte-stream UART port and a one-byte receive holding register sits. It also provides a sticky simulation-halt flag. It is the counterpart that the CPU's memory controller talks to; all timing below is what that controller relies on.

---
 rtl/mem_bus_responder.sv | 137 +++++++++++++
 tb/tb_mem_bus_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Byte-wide RAM plus memory-mapped I/O responder for the core's external bus.
// RAM reads take one cycle; 0x30000 is TX FIFO / RX holding register, 0x30004 is halt / RX status.
module mem_bus_responder #(
   parameter int    ADDR_W    = 17,
   parameter int    FIFO_AW   = 3,
   parameter string INIT_FILE = ""
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        sim_halt,
   output logic        overflow
);

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_NEAR = (FIFO_AW+1)'(DEPTH - 1);
   localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = (FIFO_AW)'(1);
   localparam logic [17:0]        IO_DATA  = 18'h30000;
   localparam logic [17:0]        IO_STAT  = 18'h30004;

   logic [7:0] ram  [0:(1 << ADDR_W) - 1];
   logic [7:0] fifo [0:DEPTH - 1];

   logic [7:0]         mem_din_q, mem_din_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [7:0]         rx_buf_q, rx_buf_d;
   logic               rx_full_q, rx_full_d;
   logic               sim_halt_q, sim_halt_d;
   logic               overflow_q, overflow_d;

   logic io_sel, sel_data, sel_stat;
   logic ram_we, tx_push, tx_pop, tx_accept, rx_load, rx_take;

   // Bits above the decoded window are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^mem_a[31:18];

   assign io_sel   = (mem_a[17:16] == 2'b11);
   assign sel_data = (mem_a[17:0] == IO_DATA);
   assign sel_stat = (mem_a[17:0] == IO_STAT);

   assign ram_we    = mem_wr && !io_sel;
   assign tx_push   = mem_wr && sel_data;
   assign tx_pop    = tx_valid && tx_ready;
   assign tx_accept = tx_push && ((count_q < CNT_FULL) || tx_pop);
   assign rx_load   = rx_valid && rx_ready;
   assign rx_take   = !mem_wr && sel_data;

   assign mem_din        = mem_din_q;
   assign tx_valid       = (count_q != '0);
   assign tx_data        = fifo[rptr_q];
   assign io_buffer_full = (count_q >= CNT_NEAR);
   assign rx_ready       = !rx_full_q;
   assign sim_halt       = sim_halt_q;
   assign overflow       = overflow_q;

   // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
   always_comb begin
      mem_din_d  = mem_din_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      rx_buf_d   = rx_buf_q;
      rx_full_d  = rx_full_q;
      sim_halt_d = sim_halt_q;
      overflow_d = overflow_q;

      if (!mem_wr) begin
         if (!io_sel)       mem_din_d = ram[mem_a[ADDR_W-1:0]];
         else if (sel_data) mem_din_d = rx_full_q ? rx_buf_q : 8'h00;
         else if (sel_stat) mem_din_d = {7'b0, rx_full_q};
         else               mem_din_d = 8'h00;
      end

      if (tx_accept) wptr_d = wptr_q + PTR_ONE;
      if (tx_pop)    rptr_d = rptr_q + PTR_ONE;
      case ({tx_accept, tx_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (tx_push && !tx_accept) overflow_d = 1'b1;

      if (mem_wr && sel_stat) sim_halt_d = 1'b1;

      // A load only happens while empty, so it never races a consuming read of live data.
      if (rx_load) begin
         rx_buf_d  = rx_data;
         rx_full_d = 1'b1;
      end else if (rx_take) begin
         rx_full_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din_q  <= 8'h00;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         rx_buf_q   <= 8'h00;
         rx_full_q  <= 1'b0;
         sim_halt_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         mem_din_q  <= mem_din_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rx_buf_q   <= rx_buf_d;
         rx_full_q  <= rx_full_d;
         sim_halt_q <= sim_halt_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage arrays stay outside the reset so they map onto block RAM and survive reset.
   always_ff @(posedge clk_in) begin
      if (ram_we)    ram[mem_a[ADDR_W-1:0]] <= mem_dout;
      if (tx_accept) fifo[wptr_q] <= mem_dout;
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed bus/TX/RX stimulus,
// expected read data and TX bytes queued at issue time and compared by a separate monitor.
module tb_mem_bus_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        sim_halt;
   logic        overflow;

   mem_bus_responder #(.ADDR_W(17), .FIFO_AW(3), .INIT_FILE("")) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .sim_halt       (sim_halt),
      .overflow       (overflow)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;

   exp_t       rdq[$];
   logic [7:0] txq[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       chk_rd  = 1'b0;
   logic       chk_q   = 1'b0;
   exp_t       mon_e;
   logic [7:0] mon_b;
   int         iters;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic chk, input logic [7:0] e, input string nm);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      chk_rd   = chk;
      if (chk) rdq.push_back('{nm, e});
      cyc();
   endtask

   task automatic idle();
      mem_a  = 32'h0;
      mem_wr = 1'b0;
      chk_rd = 1'b0;
   endtask

   task automatic tx_write(input logic [7:0] b, input logic expect_kept);
      if (expect_kept) txq.push_back(b);
      bus(32'h30000, 1'b1, b, 1'b0, 8'h00, "");
   endtask

   task automatic drain(input string nm, input int nbytes);
      idle();
      tx_ready = 1'b1;
      iters = 0;
      while (txq.size() != 0 && iters < 40) begin
         cyc();
         iters++;
      end
      check({nm, "_left"}, txq.size(), 0);
      check({nm, "_cycles"}, iters, nbytes);
      cyc();
      tx_ready = 1'b0;
      check({nm, "_valid_after"}, tx_valid, 1'b0);
   endtask

   // Read-data monitor: a read tagged in cycle N is compared after edge N+1.
   always @(posedge clk_in) chk_q <= chk_rd;

   always @(negedge clk_in) begin
      if (chk_q) begin
         if (rdq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_underflow: got mem_din 0x%0h with no expectation queued", mem_din);
         end else begin
            mon_e = rdq.pop_front();
            check(mon_e.name, mem_din, mon_e.val);
         end
      end
      if (tx_valid && tx_ready) begin
         if (txq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got tx_data 0x%0h with no expectation queued", tx_data);
         end else begin
            mon_b = txq.pop_front();
            check("tx_byte", tx_data, mon_b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in   = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      mem_dout = 8'h00;
      idle();
      #2;
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_buf_full", io_buffer_full, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      check("rst_sim_halt", sim_halt, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      #10 rst_in = 1'b1;
      cyc();

      // RAM: write/read, hold on write, streaming reads, unmapped I/O
      bus(32'h00010, 1'b1, 8'hA5, 1'b0, 8'h00, "");
      bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_wr_rd");
      bus(32'h00011, 1'b1, 8'h3C, 1'b1, 8'hA5, "hold_on_wr");
      bus(32'h00012, 1'b1, 8'h7E, 1'b0, 8'h00, "");
      bus(32'h00013, 1'b1, 8'hC3, 1'b0, 8'h00, "");
      bus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5, "stream_0");
      bus(32'h00011, 1'b0, 8'h00, 1'b1, 8'h3C, "stream_1");
      bus(32'h00012, 1'b0, 8'h00, 1'b1, 8'h7E, "stream_2");
      bus(32'h00013, 1'b0, 8'h00, 1'b1, 8'hC3, "stream_3");
      bus(32'h30008, 1'b0, 8'h00, 1'b1, 8'h00, "io_other_rd");
      bus(32'hFFF00013, 1'b0, 8'h00, 1'b1, 8'hC3, "upper_bits_ignored");

      // TX drain of three bytes
      check("tx_idle_valid", tx_valid, 1'b0);
      tx_write(8'h41, 1'b1);
      check("tx_valid_rise", tx_valid, 1'b1);
      tx_write(8'h42, 1'b1);
      tx_write(8'h43, 1'b1);
      idle();
      cyc();
      check("tx_head", tx_data, 8'h41);
      check("tx3_not_full", io_buffer_full, 1'b0);
      drain("tx3", 3);

      // Fill to DEPTH, overflow, push+pop at full, wrap-around order
      for (int i = 1; i <= 7; i++) begin
         tx_write(8'(i), 1'b1);
         if (i == 6) check("full_at_6", io_buffer_full, 1'b0);
      end
      check("full_at_7", io_buffer_full, 1'b1);
      tx_write(8'h08, 1'b1);
      check("ovf_at_8", overflow, 1'b0);
      tx_write(8'h09, 1'b0);
      check("ovf_at_9", overflow, 1'b1);
      tx_ready = 1'b1;
      tx_write(8'h0A, 1'b1);
      tx_ready = 1'b0;
      check("full_after_pushpop", io_buffer_full, 1'b1);
      tx_write(8'h0B, 1'b0);
      check("ovf_sticky", overflow, 1'b1);
      drain("tx8", 8);
      check("full_after_drain", io_buffer_full, 1'b0);

      // RX holding register
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      cyc();
      check("rx_ready_low", rx_ready, 1'b0);
      rx_data = 8'h77;
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h01, "rx_status_full");
      rx_valid = 1'b0;
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h5A, "rx_read");
      check("rx_ready_back", rx_ready, 1'b1);
      bus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00, "rx_read_empty");
      bus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h00, "rx_status_empty");

      // Halt, then asynchronous reset in the middle of a TX drain
      bus(32'h00040, 1'b1, 8'h99, 1'b0, 8'h00, "");
      bus(32'h00040, 1'b0, 8'h00, 1'b1, 8'h99, "pre_rst_rd");
      bus(32'h30004, 1'b1, 8'h00, 1'b1, 8'h99, "halt_wr_hold");
      check("halt_set", sim_halt, 1'b1);
      tx_write(8'hB1, 1'b1);
      tx_write(8'hB2, 1'b1);
      tx_write(8'hB3, 1'b1);
      idle();
      check("halt_sticky", sim_halt, 1'b1);
      tx_ready = 1'b1;
      cyc();
      #2 rst_in = 1'b0;
      #1;
      check("arst_tx_valid", tx_valid, 1'b0);
      check("arst_sim_halt", sim_halt, 1'b0);
      check("arst_mem_din", mem_din, 8'h00);
      check("arst_overflow", overflow, 1'b0);
      check("arst_rx_ready", rx_ready, 1'b1);
      txq.delete();
      tx_ready = 1'b0;
      #4 rst_in = 1'b1;
      cyc();
      bus(32'h00040, 1'b0, 8'h00, 1'b1, 8'h99, "ram_survives_rst");
      bus(32'h00013, 1'b0, 8'h00, 1'b1, 8'hC3, "ram_survives_rst2");
      idle();
      cyc();
      cyc();
      check("rd_queue_empty", rdq.size(), 0);
      check("tx_queue_empty", txq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
